cfg_regbank: RTL and testbench

- Runtime-programmable configuration register bank. It is the parametrised successor to the fixed per-constant tie-off instances used at top level.
- Holds NUM_REGS words of DATA_W bits. Defaults are loaded at reset; writes land in a staging copy.
- Staging is copied atomically to the active copy only when a commit is requested and the datapath signals a safe point (frame boundary).
- The active copy drives MODE_CTRL, DELAY_CNT, the loop shifts, the detector thresholds/windows and TX_PHASE_CONFIG into Tx/Rx.

---
 rtl/cfg_regbank_if.sv | 24 ++
 rtl/cfg_regbank.sv | 148 ++++++++++++++
 tb/tb_cfg_regbank.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_regbank_if.sv
// rtl/cfg_regbank_if.sv - write channel into the configuration staging copy
interface cfg_regbank_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/cfg_regbank.sv
// rtl/cfg_regbank.sv - staged config bank, atomic staging->active copy at a safe point
// Optional commit timeout is built only when CFG_COMMIT_TIMEOUT_EN is defined.
module cfg_regbank #(
    parameter int unsigned NUM_REGS = 9,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter logic [NUM_REGS*DATA_W-1:0] DEFAULTS =
        {16'd8192, 16'd16, 16'd16, 16'd16, 16'd128, 16'd3, 16'd0, 16'd4, 16'd8}
`ifdef CFG_COMMIT_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
    input  logic                       clk_16M384,
    input  logic                       rst_n_16M384,
    cfg_regbank_if.slave               wr,
    input  logic                       commit_req,
    input  logic                       abort_req,
    input  logic                       safe_point,
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_sel,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*DATA_W-1:0] cfg_active,
    output logic                       cfg_update,
    output logic                       pending,
    output logic                       err_addr,
    output logic                       timeout_flag
);

    typedef enum logic {
        S_IDLE,
        S_PENDING
    } state_t;

    localparam logic [ADDR_W:0] NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

    state_t            state;
    logic [DATA_W-1:0] staging [NUM_REGS];
    logic [DATA_W-1:0] active  [NUM_REGS];
    logic              wr_in_range;
    logic              rd_in_range;

    assign wr_in_range = ({1'b0, wr.wr_addr} < NUM_REGS_X);
    assign rd_in_range = ({1'b0, rd_addr} < NUM_REGS_X);

    // Writes stall while a commit is outstanding so the copied image is coherent.
    assign wr.wr_ready = (state == S_IDLE);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_active[g*DATA_W +: DATA_W] = active[g];
    end

`ifdef CFG_COMMIT_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            cfg_update <= 1'b0;
            err_addr   <= 1'b0;
            rd_data    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                staging[i] <= DEFAULTS[i*DATA_W +: DATA_W];
                active[i]  <= DEFAULTS[i*DATA_W +: DATA_W];
            end
`ifdef CFG_COMMIT_TIMEOUT_EN
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            cfg_update <= 1'b0;

            if (rd_in_range) begin
                rd_data <= rd_sel ? staging[rd_addr] : active[rd_addr];
            end else begin
                rd_data <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (abort_req) begin
                        // Abort beats a same-cycle commit and swallows a same-cycle write.
                        for (int i = 0; i < NUM_REGS; i++) begin
                            staging[i] <= active[i];
                        end
                    end else begin
                        if (wr.wr_valid) begin
                            if (wr_in_range) begin
                                staging[wr.wr_addr] <= wr.wr_data;
                            end else begin
                                err_addr <= 1'b1;
                            end
                        end
                        if (commit_req) begin
                            state   <= S_PENDING;
                            pending <= 1'b1;
`ifdef CFG_COMMIT_TIMEOUT_EN
                            to_cnt  <= '0;
`endif
                        end
                    end
                end

                S_PENDING: begin
                    if (abort_req) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            staging[i] <= active[i];
                        end
                        pending <= 1'b0;
                        state   <= S_IDLE;
                    end else if (safe_point) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            active[i] <= staging[i];
                        end
                        cfg_update <= 1'b1;
                        pending    <= 1'b0;
                        err_addr   <= 1'b0;
                        state      <= S_IDLE;
                    end
`ifdef CFG_COMMIT_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            staging[i] <= active[i];
                        end
                        pending      <= 1'b0;
                        timeout_flag <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end

                default: begin
                    state   <= S_IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_regbank.sv
// tb/tb_cfg_regbank.sv - directed plus randomized bench for cfg_regbank against a reference model
module tb_cfg_regbank;

    localparam int NR     = 9;
    localparam int DW     = 16;
    localparam int AW     = 4;
    localparam int TO_CYC = 20;
    localparam logic [NR*DW-1:0] DEF =
        {16'd8192, 16'd16, 16'd16, 16'd16, 16'd128, 16'd3, 16'd0, 16'd4, 16'd8};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cfg_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) wr_bus ();

    logic            commit_req = 1'b0;
    logic            abort_req  = 1'b0;
    logic            safe_point = 1'b0;
    logic [AW-1:0]   rd_addr    = '0;
    logic            rd_sel     = 1'b0;
    logic [DW-1:0]   rd_data;
    logic [NR*DW-1:0] cfg_active;
    logic            cfg_update;
    logic            pending;
    logic            err_addr;
    logic            timeout_flag;

    cfg_regbank #(
        .NUM_REGS(NR),
        .DATA_W(DW),
        .ADDR_W(AW)
`ifdef CFG_COMMIT_TIMEOUT_EN
        , .TIMEOUT_CYC(TO_CYC)
`endif
    ) dut (
        .clk_16M384   (clk),
        .rst_n_16M384 (rst_n),
        .wr           (wr_bus),
        .commit_req   (commit_req),
        .abort_req    (abort_req),
        .safe_point   (safe_point),
        .rd_addr      (rd_addr),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .cfg_active   (cfg_active),
        .cfg_update   (cfg_update),
        .pending      (pending),
        .err_addr     (err_addr),
        .timeout_flag (timeout_flag)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: two word arrays plus the visible flags.
    logic [DW-1:0] m_stg [NR];
    logic [DW-1:0] m_act [NR];
    logic [DW-1:0] m_rd;
    logic          m_pend, m_err, m_to, m_upd;
    int            m_wait;

    task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [NR*DW-1:0] model_active();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_act[i];
        return f;
    endfunction

    function automatic logic [DW-1:0] dut_word(input int i);
        return cfg_active[i*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_stg[i] = DEF[i*DW +: DW];
            m_act[i] = DEF[i*DW +: DW];
        end
        m_rd = '0; m_pend = 0; m_err = 0; m_to = 0; m_upd = 0; m_wait = 0;
    endtask

    task automatic model_step();
        m_upd = 0;
        m_rd  = (int'(rd_addr) < NR) ? (rd_sel ? m_stg[rd_addr] : m_act[rd_addr]) : '0;
        if (!m_pend) begin
            if (abort_req) begin
                m_stg = m_act;
            end else begin
                if (wr_bus.wr_valid) begin
                    if (int'(wr_bus.wr_addr) < NR) m_stg[wr_bus.wr_addr] = wr_bus.wr_data;
                    else m_err = 1;
                end
                if (commit_req) begin
                    m_pend = 1;
                    m_wait = 0;
                end
            end
        end else if (abort_req) begin
            m_stg  = m_act;
            m_pend = 0;
        end else if (safe_point) begin
            m_act  = m_stg;
            m_upd  = 1;
            m_pend = 0;
            m_err  = 0;
        end else begin
            m_wait++;
`ifdef CFG_COMMIT_TIMEOUT_EN
            if (m_wait == TO_CYC) begin
                m_stg  = m_act;
                m_pend = 0;
                m_to   = 1;
            end
`endif
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("cfg_active", cfg_active, model_active());
            chk("cfg_update", NR*DW'(cfg_update), NR*DW'(m_upd));
            chk("pending", NR*DW'(pending), NR*DW'(m_pend));
            chk("err_addr", NR*DW'(err_addr), NR*DW'(m_err));
            chk("timeout_flag", NR*DW'(timeout_flag), NR*DW'(m_to));
            chk("wr_ready", NR*DW'(wr_bus.wr_ready), NR*DW'(!m_pend));
            chk("rd_data", NR*DW'(rd_data), NR*DW'(m_rd));
        end
    end

    task automatic drive_write(input int addr, input int data);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_addr  = AW'(addr);
        wr_bus.wr_data  = DW'(data);
    endtask

    task automatic clear_inputs();
        wr_bus.wr_valid = 1'b0;
        commit_req = 1'b0;
        abort_req  = 1'b0;
        safe_point = 1'b0;
    endtask

    int exp_stg [NR] = '{8, 2, 0, 3, 128, 16, 16, 16, 8192};
    int cnt;

    initial begin
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_addr  = '0;
        wr_bus.wr_data  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cfg_active", cfg_active, DEF);
        chk("rst_pending", NR*DW'(pending), '0);
        chk("rst_err", NR*DW'(err_addr), '0);
        chk("rst_timeout", NR*DW'(timeout_flag), '0);
        chk("rst_rd_data", NR*DW'(rd_data), '0);
        rst_n = 1'b1;
        chk("rst_word0", NR*DW'(dut_word(0)), NR*DW'(8));
        chk("rst_word8", NR*DW'(dut_word(8)), NR*DW'(8192));
        rd_addr = 4'd4; rd_sel = 1'b0;
        @(negedge clk);
        chk("rd_word4", NR*DW'(rd_data), NR*DW'(128));

        // Commit waits for safe_point
        drive_write(1, 2);
        @(negedge clk); clear_inputs();
        commit_req = 1'b1;
        @(negedge clk); clear_inputs();
        for (int i = 0; i < 10; i++) begin
            chk("wait_pending", NR*DW'(pending), NR*DW'(1));
            chk("wait_word1", NR*DW'(dut_word(1)), NR*DW'(4));
            chk("wait_wr_ready", NR*DW'(wr_bus.wr_ready), '0);
            @(negedge clk);
        end
        safe_point = 1'b1;
        @(negedge clk); clear_inputs();
        chk("commit_word1", NR*DW'(dut_word(1)), NR*DW'(2));
        chk("commit_update", NR*DW'(cfg_update), NR*DW'(1));
        @(negedge clk);
        chk("update_single", NR*DW'(cfg_update), '0);

        // Out-of-range write
        drive_write(12, 16'hFFFF);
        @(negedge clk); clear_inputs();
        chk("err_set", NR*DW'(err_addr), NR*DW'(1));
        rd_sel = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            chk("stg_after_bad_wr", NR*DW'(rd_data), NR*DW'(exp_stg[i]));
        end
        commit_req = 1'b1;
        @(negedge clk); clear_inputs();
        safe_point = 1'b1;
        @(negedge clk); clear_inputs();
        chk("err_cleared", NR*DW'(err_addr), '0);

        // Abort in IDLE, then abort while PENDING
        drive_write(3, 7);
        @(negedge clk); clear_inputs();
        abort_req = 1'b1;
        @(negedge clk); clear_inputs();
        chk("abort_no_update", NR*DW'(cfg_update), '0);
        rd_sel = 1'b1; rd_addr = 4'd3;
        @(negedge clk);
        chk("abort_stg3", NR*DW'(rd_data), NR*DW'(3));
        drive_write(3, 7);
        @(negedge clk); clear_inputs();
        commit_req = 1'b1;
        @(negedge clk); clear_inputs();
        chk("pend_before_abort", NR*DW'(pending), NR*DW'(1));
        abort_req = 1'b1;
        @(negedge clk); clear_inputs();
        chk("pend_abort_drop", NR*DW'(pending), '0);
        chk("pend_abort_word3", NR*DW'(dut_word(3)), NR*DW'(3));

        // Same-cycle write + commit, then commit + abort together
        drive_write(0, 5);
        commit_req = 1'b1;
        @(negedge clk); clear_inputs();
        safe_point = 1'b1;
        @(negedge clk); clear_inputs();
        chk("samecyc_word0", NR*DW'(dut_word(0)), NR*DW'(5));
        drive_write(0, 9);
        commit_req = 1'b1;
        abort_req  = 1'b1;
        @(negedge clk); clear_inputs();
        chk("ca_pending", NR*DW'(pending), '0);
        chk("ca_wr_ready", NR*DW'(wr_bus.wr_ready), NR*DW'(1));
        chk("ca_word0", NR*DW'(dut_word(0)), NR*DW'(5));

        // Commit with no safe point
        commit_req = 1'b1;
        @(negedge clk); clear_inputs();
`ifdef CFG_COMMIT_TIMEOUT_EN
        cnt = 0;
        while (pending && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_cycles", NR*DW'(cnt), NR*DW'(TO_CYC));
        chk("to_flag", NR*DW'(timeout_flag), NR*DW'(1));
        chk("to_pending", NR*DW'(pending), '0);
        chk("to_word0", NR*DW'(dut_word(0)), NR*DW'(5));
`else
        repeat (1000) @(negedge clk);
        chk("no_to_pending", NR*DW'(pending), NR*DW'(1));
        chk("no_to_flag", NR*DW'(timeout_flag), '0);
        abort_req = 1'b1;
        @(negedge clk); clear_inputs();
`endif

        // Reset mid-PENDING
        commit_req = 1'b1;
        @(negedge clk); clear_inputs();
        chk("mid_pending", NR*DW'(pending), NR*DW'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_pending", NR*DW'(pending), '0);
        chk("mid_rst_active", cfg_active, DEF);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            wr_bus.wr_valid = 1'($urandom_range(0, 1));
            wr_bus.wr_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(9, 15)) : AW'($urandom_range(0, 8));
            wr_bus.wr_data  = DW'($urandom);
            commit_req      = ($urandom_range(0, 9) == 0);
            abort_req       = ($urandom_range(0, 19) == 0);
            safe_point      = ($urandom_range(0, 4) == 0);
            rd_addr         = AW'($urandom_range(0, 15));
            rd_sel          = 1'($urandom_range(0, 1));
        end
        @(negedge clk); clear_inputs();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
